// File: rtl/sync_frame_pkg.sv
// Shared types and widths for the packet framing controller.
package sync_frame_pkg;

  localparam int BYTE_W    = 8;
  localparam int BIT_CNT_W = 3;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    DONE    = 3'd3,
    ERR     = 3'd4
  } state_t;

endpackage

// File: rtl/serial_byte_deser.sv
// LSB-first serial-to-byte deserializer with a bit counter.
// byte_out is the value the register would hold after shifting in the
// current bit, so a consumer can grab the completed byte on the same
// cycle byte_done fires.
module serial_byte_deser
  import sync_frame_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              shift_en,
  input  logic              serial_in,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_done
);

  logic [BYTE_W-1:0]    r_sr;
  logic [BIT_CNT_W-1:0] r_bit_cnt;

  assign byte_out  = {serial_in, r_sr[BYTE_W-1:1]};
  assign byte_done = shift_en && (r_bit_cnt == BIT_CNT_W'(BYTE_W - 1));

  // Shift register and bit counter; the counter wraps to 0 after the 8th bit.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sr      <= '0;
      r_bit_cnt <= '0;
    end else if (clear) begin
      r_sr      <= '0;
      r_bit_cnt <= '0;
    end else if (shift_en) begin
      r_sr      <= byte_out;
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sync_frame_ctrl.sv
// Packet framing controller: hunts for sync via an external detector,
// then captures a length byte and deserializes that many payload bytes.
module sync_frame_ctrl
  import sync_frame_pkg::*;
#(
  parameter int MAX_LEN     = 64,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              enable,
  input  logic              shift_en,
  input  logic              serial_in,
  input  logic              sync_det,
  output logic              det_shift_en,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  output logic [BYTE_W-1:0] byte_cnt,
  output logic              busy,
  output logic              packet_done,
  output logic              packet_err
);

  localparam int                IDLE_W    = $clog2(TIMEOUT_CYC);
  localparam logic [BYTE_W-1:0] MAX_LEN_B = BYTE_W'(MAX_LEN);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_in_frame;
  logic              w_shift;
  logic              w_lock;
  logic              w_len_ok;
  logic              w_byte_rx;
  logic              w_des_clear;
  logic              w_des_shift;
  logic [BYTE_W-1:0] w_des_byte;
  logic              w_des_done;

  logic [IDLE_W-1:0] r_idle_cnt;
  logic [BYTE_W-1:0] r_len;
  logic [BYTE_W-1:0] r_byte_cnt;
  logic [BYTE_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  assign w_in_frame  = (r_state == LEN) || (r_state == PAYLOAD);
  assign w_shift     = shift_en && enable;
  assign w_des_shift = w_shift && w_in_frame;
  // Outside a frame the deserializer is held clear so each lock starts at bit 0.
  assign w_des_clear = !w_in_frame;

  assign det_shift_en = w_shift && (r_state == HUNT);
  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign byte_cnt     = r_byte_cnt;
  assign busy         = r_busy;
  assign packet_done  = r_done;
  assign packet_err   = r_err;

  serial_byte_deser u_deser (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear     (w_des_clear),
    .shift_en  (w_des_shift),
    .serial_in (serial_in),
    .byte_out  (w_des_byte),
    .byte_done (w_des_done)
  );

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= HUNT;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; enable loss beats a completing bit, timeout only when idle.
  always_comb begin
    w_state_nxt = r_state;
    w_lock      = 1'b0;
    w_len_ok    = 1'b0;
    w_byte_rx   = 1'b0;
    case (r_state)
      HUNT: begin
        if (w_shift && sync_det) begin
          w_state_nxt = LEN;
          w_lock      = 1'b1;
        end
      end
      LEN, PAYLOAD: begin
        if (!enable) begin
          w_state_nxt = ERR;
        end else if (w_des_done) begin
          if (r_state == LEN) begin
            if ((w_des_byte == '0) || (w_des_byte > MAX_LEN_B)) begin
              w_state_nxt = ERR;
            end else begin
              w_state_nxt = PAYLOAD;
              w_len_ok    = 1'b1;
            end
          end else begin
            w_byte_rx = 1'b1;
            if ((r_byte_cnt + 1'b1) == r_len) w_state_nxt = DONE;
          end
        end else if (!shift_en && (r_idle_cnt == IDLE_LAST)) begin
          w_state_nxt = ERR;
        end
      end
      DONE:    w_state_nxt = HUNT;
      ERR:     w_state_nxt = HUNT;
      default: w_state_nxt = HUNT;
    endcase
  end

  // Idle counter: counts cycles without a bit while inside a frame.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                      r_idle_cnt <= '0;
    else if (w_in_frame && !w_shift) r_idle_cnt <= r_idle_cnt + 1'b1;
    else                             r_idle_cnt <= '0;
  end

  // Length capture and payload byte counter; count survives until next lock.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_len      <= '0;
      r_byte_cnt <= '0;
    end else begin
      if (w_len_ok) r_len <= w_des_byte;
      if (w_lock || w_len_ok) r_byte_cnt <= '0;
      else if (w_byte_rx)     r_byte_cnt <= r_byte_cnt + 1'b1;
    end
  end

  // Registered outputs: data byte, pulses and busy flag.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_byte_rx) r_rx_data <= w_des_byte;
      r_rx_valid <= w_byte_rx;
      r_busy     <= (w_state_nxt == LEN) || (w_state_nxt == PAYLOAD);
      r_done     <= (w_state_nxt == DONE);
      r_err      <= (w_state_nxt == ERR);
    end
  end

endmodule

// File: tb/tb_sync_frame_ctrl.sv
// Directed testbench for sync_frame_ctrl (MAX_LEN=64, TIMEOUT_CYC=16).
module tb_sync_frame_ctrl;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       enable = 1'b1;
  logic       shift_en = 1'b0;
  logic       serial_in = 1'b0;
  logic       sync_det = 1'b0;
  logic       det_shift_en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] byte_cnt;
  logic       busy;
  logic       packet_done;
  logic       packet_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Event monitor state
  logic [7:0] rx_log [0:255];
  logic [7:0] wr_ptr = 8'd0;
  int n_valid = 0;
  int n_done  = 0;
  int n_err   = 0;
  int n_done_with_valid = 0;

  sync_frame_ctrl #(.MAX_LEN(64), .TIMEOUT_CYC(16)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable       (enable),
    .shift_en     (shift_en),
    .serial_in    (serial_in),
    .sync_det     (sync_det),
    .det_shift_en (det_shift_en),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .byte_cnt     (byte_cnt),
    .busy         (busy),
    .packet_done  (packet_done),
    .packet_err   (packet_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log[wr_ptr] = rx_data;
      wr_ptr = wr_ptr + 8'd1;
      n_valid++;
    end
    if (packet_done) n_done++;
    if (packet_err) n_err++;
    if (packet_done && rx_valid) n_done_with_valid++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One bit with shift_en, followed by one idle cycle.
  task automatic send_bit(input logic b, input logic s);
    shift_en = 1'b1; serial_in = b; sync_det = s;
    cyc();
    shift_en = 1'b0; serial_in = 1'b0; sync_det = 1'b0;
    cyc();
  endtask

  task automatic send_byte(input logic [7:0] v, input logic s);
    for (int i = 0; i < 8; i++) send_bit(v[i], s);
  endtask

  task automatic do_lock();
    send_bit(1'b1, 1'b1);
  endtask

  int v0, d0, e0, dv0, idle_edges;
  logic [7:0] p0;

  initial begin
    // Reset state
    #3;
    chk("rst_rx_data", 32'(rx_data), 32'h0);
    chk("rst_rx_valid", 32'(rx_valid), 32'h0);
    chk("rst_byte_cnt", 32'(byte_cnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(packet_done), 32'h0);
    chk("rst_err", 32'(packet_err), 32'h0);
    cyc(); cyc();
    n_rst = 1'b1;
    cyc(); cyc();

    // Normal frame: len 2, payload A5, 3C
    v0 = n_valid; d0 = n_done; e0 = n_err; dv0 = n_done_with_valid; p0 = wr_ptr;
    shift_en = 1'b1; sync_det = 1'b1; serial_in = 1'b1;
    #1;
    chk("hunt_det_shift_en", 32'(det_shift_en), 32'h1);
    @(posedge clk); #1;
    chk("lock_busy", 32'(busy), 32'h1);
    chk("len_det_shift_en", 32'(det_shift_en), 32'h0);
    shift_en = 1'b0; sync_det = 1'b0; serial_in = 1'b0;
    cyc();
    send_byte(8'h02, 1'b0);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h3C, 1'b0);
    chk("norm_valid_cnt", 32'(n_valid - v0), 32'd2);
    chk("norm_byte0", 32'(rx_log[p0]), 32'hA5);
    chk("norm_byte1", 32'(rx_log[p0 + 8'd1]), 32'h3C);
    chk("norm_rx_data", 32'(rx_data), 32'h3C);
    chk("norm_done_cnt", 32'(n_done - d0), 32'd1);
    chk("norm_done_with_valid", 32'(n_done_with_valid - dv0), 32'd1);
    chk("norm_err_cnt", 32'(n_err - e0), 32'd0);
    chk("norm_byte_cnt", 32'(byte_cnt), 32'd2);
    chk("norm_busy_low", 32'(busy), 32'h0);
    shift_en = 1'b1;
    #1;
    chk("norm_det_resume", 32'(det_shift_en), 32'h1);
    shift_en = 1'b0;
    cyc();

    // Bad length 0x00 and 0x41
    v0 = n_valid; e0 = n_err;
    do_lock();
    send_byte(8'h00, 1'b0);
    chk("len0_err_cnt", 32'(n_err - e0), 32'd1);
    chk("len0_valid_cnt", 32'(n_valid - v0), 32'd0);
    chk("len0_busy", 32'(busy), 32'h0);
    v0 = n_valid; e0 = n_err;
    do_lock();
    send_byte(8'h41, 1'b0);
    chk("len65_err_cnt", 32'(n_err - e0), 32'd1);
    chk("len65_valid_cnt", 32'(n_valid - v0), 32'd0);

    // Length exactly MAX_LEN is legal
    v0 = n_valid; d0 = n_done; e0 = n_err; p0 = wr_ptr;
    do_lock();
    send_byte(8'h40, 1'b0);
    for (int i = 0; i < 64; i++) send_byte(8'(i), 1'b0);
    chk("max_valid_cnt", 32'(n_valid - v0), 32'd64);
    chk("max_done_cnt", 32'(n_done - d0), 32'd1);
    chk("max_err_cnt", 32'(n_err - e0), 32'd0);
    chk("max_byte_cnt", 32'(byte_cnt), 32'd64);
    chk("max_first", 32'(rx_log[p0]), 32'h00);
    chk("max_last", 32'(rx_log[p0 + 8'd63]), 32'h3F);

    // Timeout after 3 length bits
    e0 = n_err;
    do_lock();
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    idle_edges = 1;
    while (!packet_err && idle_edges < 40) begin
      cyc();
      idle_edges++;
    end
    chk("timeout_cycles", 32'(idle_edges), 32'd16);
    chk("timeout_busy", 32'(busy), 32'h0);
    cyc(); cyc();
    chk("timeout_err_cnt", 32'(n_err - e0), 32'd1);
    // Relock after timeout
    d0 = n_done; p0 = wr_ptr;
    do_lock();
    send_byte(8'h01, 1'b0);
    send_byte(8'h5A, 1'b0);
    chk("relock_done_cnt", 32'(n_done - d0), 32'd1);
    chk("relock_data", 32'(rx_log[p0]), 32'h5A);

    // Sync pattern inside payload is data
    d0 = n_done; e0 = n_err; v0 = n_valid;
    do_lock();
    send_byte(8'h01, 1'b0);
    send_byte(8'hFF, 1'b1);
    chk("inpay_rx_data", 32'(rx_data), 32'hFF);
    chk("inpay_valid_cnt", 32'(n_valid - v0), 32'd1);
    chk("inpay_done_cnt", 32'(n_done - d0), 32'd1);
    chk("inpay_err_cnt", 32'(n_err - e0), 32'd0);
    chk("inpay_byte_cnt", 32'(byte_cnt), 32'd1);

    // Reset mid-frame after one payload byte
    do_lock();
    send_byte(8'h02, 1'b0);
    send_byte(8'h11, 1'b0);
    chk("mid_rx_data", 32'(rx_data), 32'h11);
    chk("mid_byte_cnt", 32'(byte_cnt), 32'd1);
    d0 = n_done; e0 = n_err;
    n_rst = 1'b0;
    #2;
    chk("arst_rx_data", 32'(rx_data), 32'h0);
    chk("arst_byte_cnt", 32'(byte_cnt), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_rx_valid", 32'(rx_valid), 32'h0);
    cyc(); cyc();
    n_rst = 1'b1;
    cyc();
    shift_en = 1'b1;
    #1;
    chk("arst_hunt", 32'(det_shift_en), 32'h1);
    shift_en = 1'b0;
    cyc(); cyc();
    chk("arst_no_done", 32'(n_done - d0), 32'd0);
    chk("arst_no_err", 32'(n_err - e0), 32'd0);
    d0 = n_done; p0 = wr_ptr;
    do_lock();
    send_byte(8'h01, 1'b0);
    send_byte(8'h77, 1'b0);
    chk("arst_fresh_done", 32'(n_done - d0), 32'd1);
    chk("arst_fresh_data", 32'(rx_log[p0]), 32'h77);

    // Enable drop in payload; that cycle's bit is discarded
    v0 = n_valid;
    do_lock();
    send_byte(8'h02, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    enable = 1'b0; shift_en = 1'b1; serial_in = 1'b1;
    cyc();
    shift_en = 1'b0; serial_in = 1'b0;
    chk("endrop_err", 32'(packet_err), 32'h1);
    chk("endrop_busy", 32'(busy), 32'h0);
    chk("endrop_no_valid", 32'(n_valid - v0), 32'd0);
    cyc();
    chk("endrop_err_pulse", 32'(packet_err), 32'h0);
    // With enable low in HUNT, sync_det is ignored
    shift_en = 1'b1; sync_det = 1'b1; serial_in = 1'b1;
    #1;
    chk("dis_det_shift_en", 32'(det_shift_en), 32'h0);
    @(posedge clk); #1;
    shift_en = 1'b0; sync_det = 1'b0; serial_in = 1'b0;
    chk("dis_no_lock", 32'(busy), 32'h0);
    enable = 1'b1;
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
